blimp_mem_arb: RTL and testbench
================================

# blimp_mem_arb

Two-requester memory arbiter sharing one `MemIntf`-style request/response port between the instruction and data memory interfaces of a Blimp core. This allows a core with separate `inst_mem`/`data_mem` ports to run against a single-ported memory or cache. Requests are arbitrated round-robin and forwarded combinationally. The requester ID of each accepted request is recorded in an in-order tag FIFO, and the head of that FIFO steers each returning response back to its requester. The downstream memory must return responses in request order.

## Interface
- `p_req_bits`, 32+32+32+8+4, width of a packed memory request message (the `MEM_REQ` struct)
- `p_resp_bits`, 32+32+8+4, width of a packed memory response message (the `MEM_RESP` struct)
- `p_max_in_flight`, 4, tag FIFO depth (maximum outstanding requests); power of two, at least 2

- `clk`  in  1  clock
- `rst`  in  1  reset; asynchronous, active-high
- `req_val`  in  2  per-requester request valid (index 0 = inst, 1 = data)
- `req_rdy`  out  2  per-requester request ready
- `req_msg`  in  2×`p_req_bits`  per-requester request message
- `resp_val`  out  2  per-requester response valid
- `resp_rdy`  in  2  per-requester response ready
- `resp_msg`  out  2×`p_resp_bits`  per-requester response message (both lanes driven with `mem_resp_msg`)
- `mem_req_val`  out  1  downstream request valid
- `mem_req_rdy`  in  1  downstream request ready
- `mem_req_msg`  out  `p_req_bits`  downstream request message
- `mem_resp_val`  in  1  downstream response valid
- `mem_resp_rdy`  out  1  downstream response ready
- `mem_resp_msg`  in  `p_resp_bits`  downstream response message

## Operation

**State**
- `prio` (1 bit): the requester favoured on a tie.
- Tag FIFO: `p_max_in_flight` entries of 1 bit each, with head pointer, tail pointer and count (count width is clog2(`p_max_in_flight`)+1).

**Request path**
- `full` = (count == `p_max_in_flight`).
- Grant `g`:
  - If both requesters are valid, `g` = `prio`.
  - Otherwise `g` is the single valid requester.
  - If neither is valid, `g` is don't-care.
- `mem_req_val` = `req_val[g]` && !`full`.
- `mem_req_msg` = `req_msg[g]`.
- `req_rdy[i]` = (`g`==i) && `req_val[i]` && `mem_req_rdy` && !`full`. The non-granted requester always sees rdy=0.
- On request fire (`mem_req_val` && `mem_req_rdy`):
  - push `g` into the FIFO;
  - set `prio` to !`g`.

**Response path**
- `empty` = (count == 0).
- `h` = FIFO head entry.
- `resp_val[h]` = `mem_resp_val` && !`empty`. The other lane's `resp_val` is 0.
- `mem_resp_rdy` = !`empty` && `resp_rdy[h]`.
- On response fire, pop the FIFO.

**Boundary conditions**
- Full: no push, even if a pop happens in the same cycle. The FIFO does not bypass.
- Empty: `mem_resp_rdy`=0. A `mem_resp_val` arriving while empty is a protocol violation; the block holds it and never drops it.
- Push and pop in the same cycle (not full): count is unchanged and both pointers advance.
- Pointers wrap modulo `p_max_in_flight`.
- Reset mid-operation clears all in-flight tags. Responses to requests issued before reset are the environment's responsibility to discard.

## Timing
- Forwarding adds 0 cycles of latency in both directions: all val/rdy/msg outputs are combinational functions of inputs and registered state.
- State (`prio`, FIFO) updates on posedge `clk` only.
- While `rst` is high:
  - `prio`=0, count=0, head=0, tail=0;
  - `req_rdy`=0, `mem_req_val`=0, `resp_val`=0, `mem_resp_rdy`=0.
- The first cycle after reset deasserts is an ordinary cycle and may grant.
- Sustained throughput is 1 request/cycle and 1 response/cycle, provided `p_max_in_flight` covers the memory round-trip latency.

## Configuration
- `BLIMP_MEM_ARB_DATA_PRIO_EN`:
  - Defined: fixed priority, `g` = 1 whenever `req_val[1]` is high. `prio` is not implemented and requester 0 can starve.
  - Undefined (default): round-robin as described above.
- The response path is identical in both modes.

## Test plan
- **Reset.** Assert `rst` asynchronously mid-cycle with `req_val`=2'b11 → all four val/rdy outputs are 0 immediately. After release, the first grant goes to requester 0.
- **Round-robin.** Both requesters continuously valid, memory with 1-cycle send/recv delay, inst reads at 0x000/0x004/0x008 and data reads at 0x100/0x104/0x108 → downstream order is 0x000, 0x100, 0x004, 0x104, 0x008, 0x108. Each response arrives only on its own requester's lane.
- **Full FIFO.** `p_max_in_flight`=4, memory holds all responses → exactly 4 requests fire; `req_rdy`=0 on the 5th. One response pop reopens issue on the following cycle.
- **Response backpressure.** Head tag = data, `resp_rdy[1]`=0 for 3 cycles → `mem_resp_rdy`=0 for those cycles. The response is delivered with data 0xDEADBEEF when `resp_rdy[1]` rises, and `resp_val[0]` stays 0 throughout.
- **Simultaneous push/pop.** At count=2, one request fires and one response fires in the same cycle → count remains 2 and the tag order is preserved.
- **Integration.** Full core test suite (addi/add/mul/lw/sw/jal/jalr, directed and golden) runs through the arbiter on a single-port test memory. Run with the default configuration and again with `BLIMP_MEM_ARB_DATA_PRIO_EN` defined → all instruction traces match the FL model.

Source files
------------

// File: rtl/blimp_mem_arb_if.sv
// ---------------------------------------------------------------------------
// blimp_mem_arb_if
//
// Bundles every handshake/bus signal around the two-requester memory arbiter:
// the two upstream requester lanes (index 0 = instruction, 1 = data) and the
// single downstream memory port.
//
// Modports
//   slave  : arbiter view (receives upstream requests and memory responses,
//            drives upstream responses and downstream requests)
//   master : environment view (core + memory side), the mirror of slave
//
// Signals
//   req_val/req_rdy/req_msg      upstream request handshake, 2 lanes
//   resp_val/resp_rdy/resp_msg   upstream response handshake, 2 lanes
//   mem_req_val/rdy/msg          downstream request handshake
//   mem_resp_val/rdy/msg         downstream response handshake
// ---------------------------------------------------------------------------
interface blimp_mem_arb_if #(
    parameter int p_req_bits  = 32 + 32 + 32 + 8 + 4,
    parameter int p_resp_bits = 32 + 32 + 8 + 4
);
    logic [1:0]                  req_val;
    logic [1:0]                  req_rdy;
    logic [1:0][p_req_bits-1:0]  req_msg;

    logic [1:0]                  resp_val;
    logic [1:0]                  resp_rdy;
    logic [1:0][p_resp_bits-1:0] resp_msg;

    logic                        mem_req_val;
    logic                        mem_req_rdy;
    logic [p_req_bits-1:0]       mem_req_msg;

    logic                        mem_resp_val;
    logic                        mem_resp_rdy;
    logic [p_resp_bits-1:0]      mem_resp_msg;

    modport slave (
        input  req_val, req_msg, resp_rdy, mem_req_rdy, mem_resp_val, mem_resp_msg,
        output req_rdy, resp_val, resp_msg, mem_req_val, mem_req_msg, mem_resp_rdy
    );

    modport master (
        output req_val, req_msg, resp_rdy, mem_req_rdy, mem_resp_val, mem_resp_msg,
        input  req_rdy, resp_val, resp_msg, mem_req_val, mem_req_msg, mem_resp_rdy
    );
endinterface

// File: rtl/blimp_mem_arb.sv
// ---------------------------------------------------------------------------
// blimp_mem_arb
//
// Shares one memory request/response port between the instruction (lane 0)
// and data (lane 1) memory interfaces of a Blimp core. Requests are
// arbitrated round-robin and forwarded combinationally; the lane id of every
// accepted request is pushed into an in-order tag FIFO whose head steers the
// next returning response back to its owner. The downstream memory must
// answer in request order.
//
// Configuration macro
//   BLIMP_MEM_ARB_DATA_PRIO_EN : when defined, the data lane wins whenever it
//                                is valid (fixed priority, no prio state);
//                                the instruction lane may starve.
//
// Parameters
//   p_req_bits      width of a packed memory request  (must match bus)
//   p_resp_bits     width of a packed memory response (must match bus)
//   p_max_in_flight tag FIFO depth, power of two, >= 2
//
// Ports
//   clk  clock
//   rst  asynchronous active-high reset; while high all val/rdy outputs are 0
//   bus  blimp_mem_arb_if.slave (upstream lanes + downstream memory port)
// ---------------------------------------------------------------------------

// Property checker for the arbiter; holds only assertions.
module blimp_mem_arb_chk #(
    parameter int p_max_in_flight = 4
) (
    input logic                                 clk,
    input logic                                 rst,
    input logic [1:0]                           req_rdy,
    input logic [1:0]                           resp_val,
    input logic                                 mem_req_val,
    input logic                                 mem_req_rdy,
    input logic                                 mem_resp_rdy,
    input logic [$clog2(p_max_in_flight):0]     count
);
    localparam int CNT_W = $clog2(p_max_in_flight) + 1;

    // At most one upstream lane is ever granted.
    a_req_rdy_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(req_rdy));

    // A response is only ever offered on one lane.
    a_resp_val_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(resp_val));

    // Occupancy never exceeds the FIFO depth.
    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        count <= CNT_W'(p_max_in_flight));

    // No response can be accepted without an outstanding tag.
    a_no_pop_empty: assert property (@(posedge clk) disable iff (rst)
        mem_resp_rdy |-> (count != {CNT_W{1'b0}}));

    // No request can issue while the tag FIFO is full.
    a_no_push_full: assert property (@(posedge clk) disable iff (rst)
        (mem_req_val && mem_req_rdy) |-> (count != CNT_W'(p_max_in_flight)));
endmodule

module blimp_mem_arb #(
    parameter int p_req_bits      = 32 + 32 + 32 + 8 + 4,
    parameter int p_resp_bits     = 32 + 32 + 8 + 4,
    parameter int p_max_in_flight = 4
) (
    input logic             clk,
    input logic             rst,
    blimp_mem_arb_if.slave  bus
);
    localparam int PTR_W = $clog2(p_max_in_flight);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(p_max_in_flight);

    // Tag FIFO storage and bookkeeping
    logic [p_max_in_flight-1:0] tags_r;
    logic [PTR_W-1:0]           head_r;
    logic [PTR_W-1:0]           tail_r;
    logic [CNT_W-1:0]           count_r;

`ifndef BLIMP_MEM_ARB_DATA_PRIO_EN
    // Lane favoured when both lanes request in the same cycle
    logic                       prio_r;
`endif

    logic                       full_s;
    logic                       empty_s;
    logic                       grant_s;
    logic                       head_tag_s;
    logic [1:0]                 req_rdy_s;
    logic                       mem_req_val_s;
    logic [p_req_bits-1:0]      mem_req_msg_s;
    logic [1:0]                 resp_val_s;
    logic                       mem_resp_rdy_s;
    logic [p_resp_bits-1:0]     mem_resp_msg_s;
    logic                       req_fire_s;
    logic                       resp_fire_s;

    // FIFO occupancy flags and the tag at the head of the FIFO.
    always_comb begin
        full_s     = (count_r == CNT_MAX);
        empty_s    = (count_r == {CNT_W{1'b0}});
        head_tag_s = tags_r[head_r];
    end

`ifdef BLIMP_MEM_ARB_DATA_PRIO_EN
    // Fixed priority: the data lane wins whenever it is valid.
    always_comb begin
        grant_s = 1'b0;
        if (bus.req_val[1]) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end
`else
    // Round-robin: a tie goes to prio_r, otherwise to the lone valid lane.
    // With no valid lane the grant is irrelevant; prio_r is reused.
    always_comb begin
        grant_s = 1'b0;
        case (bus.req_val)
            2'b11:   grant_s = prio_r;
            2'b10:   grant_s = 1'b1;
            2'b01:   grant_s = 1'b0;
            default: grant_s = prio_r;
        endcase
    end
`endif

    // Request path: forward the granted lane unless the tag FIFO is full.
    // The message mux is left ungated so it settles independently of rdy.
    always_comb begin
        req_rdy_s     = 2'b00;
        mem_req_val_s = 1'b0;
        mem_req_msg_s = bus.req_msg[grant_s];
        if (!rst && !full_s && bus.req_val[grant_s]) begin
            mem_req_val_s = 1'b1;
            if (bus.mem_req_rdy) begin
                req_rdy_s[grant_s] = 1'b1;
            end else begin
                req_rdy_s = 2'b00;
            end
        end else begin
            mem_req_val_s = 1'b0;
        end
    end

    // Response path: the head tag picks the lane. An unsolicited response
    // (FIFO empty) is never acknowledged, so it stays pending downstream.
    always_comb begin
        resp_val_s     = 2'b00;
        mem_resp_rdy_s = 1'b0;
        mem_resp_msg_s = bus.mem_resp_msg;
        if (!rst && !empty_s) begin
            resp_val_s[head_tag_s] = bus.mem_resp_val;
            mem_resp_rdy_s         = bus.resp_rdy[head_tag_s];
        end else begin
            resp_val_s     = 2'b00;
            mem_resp_rdy_s = 1'b0;
        end
    end

    // Handshake completion on each side.
    always_comb begin
        req_fire_s  = mem_req_val_s && bus.mem_req_rdy;
        resp_fire_s = mem_resp_rdy_s && bus.mem_resp_val;
    end

    assign bus.req_rdy      = req_rdy_s;
    assign bus.mem_req_val  = mem_req_val_s;
    assign bus.mem_req_msg  = mem_req_msg_s;
    assign bus.resp_val     = resp_val_s;
    assign bus.resp_msg     = {mem_resp_msg_s, mem_resp_msg_s};
    assign bus.mem_resp_rdy = mem_resp_rdy_s;

`ifndef BLIMP_MEM_ARB_DATA_PRIO_EN
    // After each issued request the other lane becomes favoured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_r <= 1'b0;
        end else if (req_fire_s) begin
            prio_r <= !grant_s;
        end else begin
            prio_r <= prio_r;
        end
    end
`endif

    // Tag storage and tail pointer: record the granted lane on issue.
    // A full FIFO never pushes, even when a pop happens in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tags_r <= {p_max_in_flight{1'b0}};
            tail_r <= {PTR_W{1'b0}};
        end else if (req_fire_s) begin
            tags_r[tail_r] <= grant_s;
            tail_r         <= tail_r + PTR_W'(1);
        end else begin
            tags_r <= tags_r;
            tail_r <= tail_r;
        end
    end

    // Head pointer: advance when a response is handed upstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r <= {PTR_W{1'b0}};
        end else if (resp_fire_s) begin
            head_r <= head_r + PTR_W'(1);
        end else begin
            head_r <= head_r;
        end
    end

    // Occupancy: simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else begin
            case ({req_fire_s, resp_fire_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    blimp_mem_arb_chk #(
        .p_max_in_flight (p_max_in_flight)
    ) u_chk (
        .clk          (clk),
        .rst          (rst),
        .req_rdy      (req_rdy_s),
        .resp_val     (resp_val_s),
        .mem_req_val  (mem_req_val_s),
        .mem_req_rdy  (bus.mem_req_rdy),
        .mem_resp_rdy (mem_resp_rdy_s),
        .count        (count_r)
    );
endmodule

// File: tb/tb_blimp_mem_arb.sv
// ---------------------------------------------------------------------------
// tb_blimp_mem_arb
//
// Drives the arbiter with directed scenarios followed by random traffic. A
// queue-based reference (lane tag queue, in-order memory queue, favoured
// lane) predicts every val/rdy/msg output each cycle; a few literal
// expectations pin down the reference itself.
// ---------------------------------------------------------------------------
module tb_blimp_mem_arb;
    localparam int REQ_W  = 32 + 32 + 32 + 8 + 4;
    localparam int RESP_W = 32 + 32 + 8 + 4;
    localparam int DEPTH  = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    blimp_mem_arb_if #(.p_req_bits(REQ_W), .p_resp_bits(RESP_W)) bus ();

    blimp_mem_arb #(
        .p_req_bits      (REQ_W),
        .p_resp_bits     (RESP_W),
        .p_max_in_flight (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference state
    bit                tagq[$];   // owner lane of each outstanding request
    logic [RESP_W-1:0] memq[$];   // responses the memory still owes, in order
    bit                prio_m;

    // Observations of the cycle just checked
    bit          last_req_fire;
    bit          last_resp_fire;
    bit          last_g;
    logic [31:0] last_req_addr;

    // Request layout used by this bench: {12 tag bits, 32 spare, addr, data}.
    function automatic logic [REQ_W-1:0] make_req(input logic [31:0] addr, input logic [31:0] data);
        return {12'h0A5, 32'h0000_0000, addr, data};
    endfunction

    function automatic logic [REQ_W-1:0] rand_req();
        return {12'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
    endfunction

    // The memory answers with the request tag, address and data field.
    function automatic logic [RESP_W-1:0] mem_answer(input logic [REQ_W-1:0] r);
        return {r[REQ_W-1:REQ_W-12], r[63:32], r[31:0]};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive_mem(input bit want);
        if (want && memq.size() > 0) begin
            bus.mem_resp_val = 1'b1;
            bus.mem_resp_msg = memq[0];
        end else begin
            bus.mem_resp_val = 1'b0;
            bus.mem_resp_msg = RESP_W'({$urandom, $urandom, $urandom});
        end
    endtask

    // Compare every DUT output with the reference, then advance the reference
    // by the handshakes that will complete at the next rising edge.
    task automatic cycle_check();
        bit         g;
        bit         h;
        bit         full;
        bit         empty;
        bit         e_mreq_val;
        bit         e_mresp_rdy;
        logic [1:0] e_req_rdy;
        logic [1:0] e_resp_val;
        #1;
        last_req_fire  = 1'b0;
        last_resp_fire = 1'b0;
        if (rst) begin
            check("rst_req_rdy", bus.req_rdy, 2'b00);
            check("rst_mem_req_val", bus.mem_req_val, 1'b0);
            check("rst_resp_val", bus.resp_val, 2'b00);
            check("rst_mem_resp_rdy", bus.mem_resp_rdy, 1'b0);
            tagq.delete();
            memq.delete();
            prio_m = 1'b0;
            return;
        end
        full  = (tagq.size() == DEPTH);
        empty = (tagq.size() == 0);
`ifdef BLIMP_MEM_ARB_DATA_PRIO_EN
        g = bus.req_val[1];
`else
        if (bus.req_val == 2'b11) g = prio_m;
        else                      g = bus.req_val[1];
`endif
        e_mreq_val = bus.req_val[g] && !full;
        e_req_rdy  = 2'b00;
        if (e_mreq_val && bus.mem_req_rdy) e_req_rdy[g] = 1'b1;
        h = empty ? 1'b0 : tagq[0];
        e_resp_val = 2'b00;
        if (!empty && bus.mem_resp_val) e_resp_val[h] = 1'b1;
        e_mresp_rdy = !empty && bus.resp_rdy[h];

        check("req_rdy", bus.req_rdy, e_req_rdy);
        check("mem_req_val", bus.mem_req_val, e_mreq_val);
        if (bus.req_val != 2'b00) check("mem_req_msg", bus.mem_req_msg, bus.req_msg[g]);
        check("resp_val", bus.resp_val, e_resp_val);
        check("mem_resp_rdy", bus.mem_resp_rdy, e_mresp_rdy);
        check("resp_msg0", bus.resp_msg[0], bus.mem_resp_msg);
        check("resp_msg1", bus.resp_msg[1], bus.mem_resp_msg);

        last_g         = g;
        last_req_addr  = bus.req_msg[g][63:32];
        last_resp_fire = e_mresp_rdy && bus.mem_resp_val;
        last_req_fire  = e_mreq_val && bus.mem_req_rdy;
        if (last_resp_fire) begin
            void'(tagq.pop_front());
            void'(memq.pop_front());
        end
        if (last_req_fire) begin
            tagq.push_back(g);
            memq.push_back(mem_answer(bus.req_msg[g]));
            prio_m = !g;
        end
    endtask

    task automatic set_inputs(input logic [1:0] rv, input logic [REQ_W-1:0] m0, input logic [REQ_W-1:0] m1,
                              input bit mrdy, input bit mresp, input logic [1:0] rrdy);
        bus.req_val     = rv;
        bus.req_msg[0]  = m0;
        bus.req_msg[1]  = m1;
        bus.mem_req_rdy = mrdy;
        bus.resp_rdy    = rrdy;
        drive_mem(mresp);
    endtask

    task automatic cyc(input bit r, input logic [1:0] rv, input logic [REQ_W-1:0] m0, input logic [REQ_W-1:0] m1,
                       input bit mrdy, input bit mresp, input logic [1:0] rrdy);
        @(negedge clk);
        rst = r;
        set_inputs(rv, m0, m1, mrdy, mresp, rrdy);
        cycle_check();
    endtask

    task automatic drain();
        for (int i = 0; i < 12; i++) cyc(1'b0, 2'b00, rand_req(), rand_req(), 1'b1, 1'b1, 2'b11);
    endtask

    initial begin
        logic [31:0] rr_seen[$];
        logic [31:0] rr_exp[6];
        int          ii;
        int          di;
        int          n_rdy;

        rst = 1'b1;
        set_inputs(2'b00, make_req(32'h0, 32'h0), make_req(32'h0, 32'h0), 1'b0, 1'b0, 2'b00);
        cyc(1'b1, 2'b11, rand_req(), rand_req(), 1'b1, 1'b0, 2'b11);
        cyc(1'b1, 2'b11, rand_req(), rand_req(), 1'b1, 1'b0, 2'b11);

        // Asynchronous reset in the middle of a cycle with both lanes valid
        cyc(1'b0, 2'b11, make_req(32'h10, 32'h0), make_req(32'h110, 32'h0), 1'b1, 1'b0, 2'b11);
        @(negedge clk);
        set_inputs(2'b11, make_req(32'h14, 32'h0), make_req(32'h114, 32'h0), 1'b1, 1'b1, 2'b11);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_req_rdy", bus.req_rdy, 2'b00);
        check("async_rst_mem_req_val", bus.mem_req_val, 1'b0);
        check("async_rst_resp_val", bus.resp_val, 2'b00);
        check("async_rst_mem_resp_rdy", bus.mem_resp_rdy, 1'b0);
        cycle_check();
        cyc(1'b1, 2'b11, rand_req(), rand_req(), 1'b1, 1'b0, 2'b11);
        cyc(1'b0, 2'b11, make_req(32'h20, 32'h0), make_req(32'h120, 32'h0), 1'b1, 1'b0, 2'b11);
`ifdef BLIMP_MEM_ARB_DATA_PRIO_EN
        check("first_grant", bus.req_rdy, 2'b10);
`else
        check("first_grant", bus.req_rdy, 2'b01);
`endif
        drain();

        // Response backpressure on the data lane
        cyc(1'b0, 2'b10, rand_req(), make_req(32'h200, 32'hDEAD_BEEF), 1'b1, 1'b0, 2'b11);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 2'b00, rand_req(), rand_req(), 1'b1, 1'b1, 2'b01);
            check("bp_mem_resp_rdy", bus.mem_resp_rdy, 1'b0);
            check("bp_resp_val", bus.resp_val, 2'b10);
        end
        cyc(1'b0, 2'b00, rand_req(), rand_req(), 1'b1, 1'b1, 2'b11);
        check("bp_release_rdy", bus.mem_resp_rdy, 1'b1);
        check("bp_release_val", bus.resp_val, 2'b10);
        check("bp_release_data", bus.resp_msg[1][31:0], 32'hDEAD_BEEF);
        drain();

        // Round-robin with both lanes continuously valid
        ii = 0;
        di = 0;
        for (int c = 0; c < 30 && rr_seen.size() < 6; c++) begin
            cyc(1'b0, {di < 3, ii < 3}, make_req(32'(ii * 4), 32'h0), make_req(32'(32'h100 + di * 4), 32'h0),
                1'b1, 1'b1, 2'b11);
            if (last_req_fire) begin
                rr_seen.push_back(last_req_addr);
                if (last_g) di++;
                else        ii++;
            end
        end
`ifdef BLIMP_MEM_ARB_DATA_PRIO_EN
        rr_exp = '{32'h100, 32'h104, 32'h108, 32'h000, 32'h004, 32'h008};
`else
        rr_exp = '{32'h000, 32'h100, 32'h004, 32'h104, 32'h008, 32'h108};
`endif
        check("rr_count", rr_seen.size(), 6);
        for (int k = 0; k < 6; k++) begin
            if (k < rr_seen.size()) check("rr_order", rr_seen[k], rr_exp[k]);
        end
        drain();

        // Full FIFO: memory withholds responses
        n_rdy = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 2'b11, rand_req(), rand_req(), 1'b1, 1'b0, 2'b11);
            if (bus.req_rdy != 2'b00) n_rdy++;
        end
        check("full_fires", n_rdy, 4);
        cyc(1'b0, 2'b11, rand_req(), rand_req(), 1'b1, 1'b1, 2'b11);
        check("full_pop_req_rdy", bus.req_rdy, 2'b00);
        check("full_pop_resp_rdy", bus.mem_resp_rdy, 1'b1);
        cyc(1'b0, 2'b11, rand_req(), rand_req(), 1'b1, 1'b0, 2'b11);
        check("full_reopen", |bus.req_rdy, 1'b1);
        drain();

        // Simultaneous push and pop at two outstanding requests
        cyc(1'b0, 2'b01, make_req(32'h300, 32'h1), rand_req(), 1'b1, 1'b0, 2'b11);
        cyc(1'b0, 2'b10, rand_req(), make_req(32'h400, 32'h2), 1'b1, 1'b0, 2'b11);
        cyc(1'b0, 2'b01, make_req(32'h304, 32'h3), rand_req(), 1'b1, 1'b1, 2'b11);
        check("pp_resp_val", bus.resp_val, 2'b01);
        check("pp_req_rdy", bus.req_rdy, 2'b01);
        cyc(1'b0, 2'b00, rand_req(), rand_req(), 1'b1, 1'b1, 2'b11);
        check("pp_order_data", bus.resp_val, 2'b10);
        cyc(1'b0, 2'b00, rand_req(), rand_req(), 1'b1, 1'b1, 2'b11);
        check("pp_order_inst", bus.resp_val, 2'b01);
        check("pp_order_msg", bus.resp_msg[0][31:0], 32'h0000_0003);
        drain();

        // Random traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 199) == 0, 2'($urandom), rand_req(), rand_req(),
                $urandom_range(0, 3) != 0, 1'($urandom), 2'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
